// File: rtl/bcd_calculator_seq.sv
// Sequential two-operand BCD calculator: button-driven digit entry, multi-cycle
// add/sub/mul/div, double-dabble conversion and a result/operand display mux.
module bcd_calculator_seq #(
  parameter int DIGITS     = 2,
  parameter int OUT_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    resetButton,
  input  logic [2*DIGITS-1:0]     inc_btn,
  input  logic [3:0]              op_btn,
  input  logic                    show_btn,
  output logic [4*OUT_DIGITS-1:0] digits,
  output logic                    neg,
  output logic                    err,
  output logic                    ovf,
  output logic                    busy,
  output logic                    done,
  output logic                    show_point
);
  localparam int OPW  = $clog2(10**DIGITS);
  localparam int RW   = 2*OPW;
  localparam int BD   = (RW*31)/100 + 1;
  localparam int CW   = (BD > OUT_DIGITS) ? BD : OUT_DIGITS;
  localparam int LO   = OUT_DIGITS - OUT_DIGITS/2;
  localparam int NA   = (DIGITS < OUT_DIGITS/2) ? DIGITS : OUT_DIGITS/2;
  localparam int NB   = (DIGITS < LO) ? DIGITS : LO;
  localparam int CNTW = $clog2(RW+1);

  typedef enum logic [1:0] {IDLE, COMPUTE, CONVERT, DONE} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  state_t state, state_nxt;
  op_t    op, op_sel;
  logic [CNTW-1:0] cnt;

  logic [2*DIGITS-1:0] inc_q, inc_edge;
  logic [3:0]          op_q, op_edge;
  logic                show_q, show_mode, start;

  logic [4*DIGITS-1:0] a_dig, b_dig;
  logic [OPW-1:0]      a_val, b_val, a_r, b_r, b_sh, q, q_nxt, rem, rem_nxt;
  logic [OPW:0]        rem_sh, diff;
  logic [RW-1:0]       acc, acc_nxt, a_sh, bin;
  logic [4*CW-1:0]     bcd, adj;
  logic [4*CW:0]       bcd_sh;
  logic                ovf_n, neg_p;
  logic [4*OUT_DIGITS-1:0] res_digits;

  // Buttons are plain levels; one action per rising edge.
  assign inc_edge = inc_btn & ~inc_q;
  assign op_edge  = op_btn & ~op_q;
  assign start    = (state == IDLE) && (op_edge != 4'b0);

  always_comb begin
    a_val = '0;
    b_val = '0;
    for (int i = DIGITS-1; i >= 0; i--) begin
      a_val = a_val * OPW'(10) + OPW'(a_dig[4*i +: 4]);
      b_val = b_val * OPW'(10) + OPW'(b_dig[4*i +: 4]);
    end
  end

  always_comb begin
    op_sel = OP_DIV;
    if (op_edge[0])      op_sel = OP_ADD;
    else if (op_edge[1]) op_sel = OP_SUB;
    else if (op_edge[2]) op_sel = OP_MUL;
  end

  // Shift-add multiply and restoring divide step.
  always_comb begin
    acc_nxt = acc + (b_sh[0] ? a_sh : '0);
    rem_sh  = {rem, q[OPW-1]};
    diff    = rem_sh - {1'b0, b_r};
    if (diff[OPW]) begin
      rem_nxt = rem_sh[OPW-1:0];
      q_nxt   = {q[OPW-2:0], 1'b0};
    end else begin
      rem_nxt = diff[OPW-1:0];
      q_nxt   = {q[OPW-2:0], 1'b1};
    end
  end

  // Double-dabble: add 3 to digits >= 5, then shift in the next magnitude bit.
  always_comb begin
    adj = bcd;
    for (int k = 0; k < CW; k++)
      if (bcd[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    bcd_sh = {adj, bin[RW-1]};
    ovf_n  = bcd_sh[4*CW];
    for (int k = OUT_DIGITS; k < CW; k++)
      if (bcd_sh[4*k +: 4] != 4'd0) ovf_n = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = COMPUTE;
      COMPUTE: if (((op == OP_ADD || op == OP_SUB) && cnt == '0) ||
                   cnt == CNTW'(OPW-1)) state_nxt = CONVERT;
      CONVERT: if (cnt == CNTW'(RW-1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetButton) begin
    if (!resetButton) state <= IDLE;
    else              state <= state_nxt;
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge resetButton) begin
    if (!resetButton) begin
      inc_q <= '0; op_q <= '0; show_q <= 1'b0; show_mode <= 1'b0;
      a_dig <= '0; b_dig <= '0; a_r <= '0; b_r <= '0; op <= OP_ADD;
      cnt <= '0; acc <= '0; a_sh <= '0; b_sh <= '0; q <= '0; rem <= '0;
      bin <= '0; bcd <= '0; neg_p <= 1'b0;
      res_digits <= '0; neg <= 1'b0; err <= 1'b0; ovf <= 1'b0;
    end else begin
      inc_q  <= inc_btn;
      op_q   <= op_btn;
      show_q <= show_btn;
      if (show_btn && !show_q) show_mode <= ~show_mode;
      cnt <= (state_nxt != state) ? '0 : cnt + CNTW'(1);
      case (state)
        IDLE: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (inc_edge[i])
              a_dig[4*i +: 4] <= (a_dig[4*i +: 4] == 4'd9) ? 4'd0 : a_dig[4*i +: 4] + 4'd1;
            if (inc_edge[DIGITS+i])
              b_dig[4*i +: 4] <= (b_dig[4*i +: 4] == 4'd9) ? 4'd0 : b_dig[4*i +: 4] + 4'd1;
          end
          if (start) begin
            op   <= op_sel;
            a_r  <= a_val;
            b_r  <= b_val;
            acc  <= '0;
            a_sh <= RW'(a_val);
            b_sh <= b_val;
            q    <= a_val;
            rem  <= '0;
          end
        end
        COMPUTE: begin
          acc  <= acc_nxt;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          q    <= q_nxt;
          rem  <= rem_nxt;
          if (state_nxt == CONVERT) begin
            bcd   <= '0;
            neg_p <= (a_r < b_r);
            case (op)
              OP_ADD:  bin <= RW'(a_r) + RW'(b_r);
              OP_SUB:  bin <= (a_r >= b_r) ? RW'(a_r - b_r) : RW'(b_r - a_r);
              OP_MUL:  bin <= acc_nxt;
              default: bin <= (b_r == '0) ? '0 : RW'(q_nxt);
            endcase
          end
        end
        CONVERT: begin
          bcd <= bcd_sh[4*CW-1:0];
          bin <= bin << 1;
          if (state_nxt == DONE) begin
            res_digits <= ovf_n ? {OUT_DIGITS{4'h9}} : bcd_sh[4*OUT_DIGITS-1:0];
            ovf <= ovf_n;
            neg <= (op == OP_SUB) && neg_p;
            err <= (op == OP_DIV) && (b_r == '0);
          end
        end
        default: ;
      endcase
    end
  end

  // Operand view: A in the upper half of the display, B in the lower half.
  always_comb begin
    digits = res_digits;
    if (show_mode) begin
      digits = '0;
      for (int k = 0; k < NB; k++) digits[4*k +: 4] = b_dig[4*k +: 4];
      for (int k = 0; k < NA; k++) digits[4*(LO+k) +: 4] = a_dig[4*k +: 4];
    end
  end

  assign show_point = show_mode;
endmodule
